// File: rtl/pea_output_drain.sv
// -----------------------------------------------------------------------------
// pea_output_drain
//
// Consumer end of the PEA output path. Pops the result and status FIFOs in
// lockstep and presents each (result, status) pair on a valid/ready port.
// Counts pairs accepted downstream (wrapping) and accepted pairs with a
// non-zero status word (saturating).
//
// Optional feature macro: PEA_DRAIN_MISMATCH_EN
//   When defined, adds a sticky 'mismatch' output. It is set when the two
//   FIFO populations differ for 4 consecutive IDLE cycles. Only reset clears it.
//
// Parameters
//   WIDTH        FIFO word width (result and status)
//   BUFFER_SIZE  depth of each output FIFO
//   POP_W        population port width, log2(BUFFER_SIZE)
//   CNT_W        width of the drained/error counters
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   result_pop     result FIFO population
//   status_pop     status FIFO population
//   result_data    result FIFO read data (one-cycle read latency)
//   status_data    status FIFO read data (one-cycle read latency)
//   rd_en_result   result FIFO read enable
//   rd_en_status   status FIFO read enable (always equal to rd_en_result)
//   out_valid      pair available on out_result/out_status
//   out_ready      downstream accepts the pair
//   out_result     registered result word
//   out_status     registered status word
//   drained_cnt    accepted pairs, wraps modulo 2^CNT_W
//   err_cnt        accepted pairs with non-zero status, saturates at all-ones
//   busy           FSM is not in IDLE
//   mismatch       (PEA_DRAIN_MISMATCH_EN only) sticky population mismatch
// -----------------------------------------------------------------------------
module pea_output_drain #(
  parameter int WIDTH       = 32,
  parameter int BUFFER_SIZE = 32,
  parameter int POP_W       = $clog2(BUFFER_SIZE),
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POP_W-1:0] result_pop,
  input  logic [POP_W-1:0] status_pop,
  input  logic [WIDTH-1:0] result_data,
  input  logic [WIDTH-1:0] status_data,
  output logic             rd_en_result,
  output logic             rd_en_status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_status,
  output logic [CNT_W-1:0] drained_cnt,
  output logic [CNT_W-1:0] err_cnt,
`ifdef PEA_DRAIN_MISMATCH_EN
  output logic             mismatch,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_rd_en;
  logic             r_valid;
  logic             r_busy;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_status;
  logic [CNT_W-1:0] r_drained;
  logic [CNT_W-1:0] r_err;

  // A pair may only be read when both FIFOs hold at least one word.
  logic w_pair_avail;
  assign w_pair_avail = (result_pop != '0) && (status_pop != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rd_en   <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_result  <= '0;
      r_status  <= '0;
      r_drained <= '0;
      r_err     <= '0;
    end else begin
      case (r_state)
        // Populations are sampled only here; later FIFO writes do not
        // affect the pair in flight.
        S_IDLE: begin
          if (w_pair_avail) begin
            r_state <= S_READ;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        // Read enable is high for exactly the READ cycle.
        S_READ: begin
          r_state <= S_WAIT;
          r_rd_en <= 1'b0;
        end
        // FIFO read data is valid during WAIT (fixed one-cycle latency).
        S_WAIT: begin
          r_result <= result_data;
          r_status <= status_data;
          r_valid  <= 1'b1;
          r_state  <= S_HOLD;
        end
        // Hold the pair stable until the downstream handshake completes.
        S_HOLD: begin
          if (out_ready) begin
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
            r_drained <= r_drained + CNT_W'(1);
            if ((r_status != '0) && (r_err != '1)) begin
              r_err <= r_err + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rd_en <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_en_result = r_rd_en;
  assign rd_en_status = r_rd_en;
  assign out_valid    = r_valid;
  assign out_result   = r_result;
  assign out_status   = r_status;
  assign drained_cnt  = r_drained;
  assign err_cnt      = r_err;
  assign busy         = r_busy;

`ifdef PEA_DRAIN_MISMATCH_EN
  logic [1:0] r_mm_cnt;
  logic       r_mismatch;

  // r_mm_cnt counts consecutive unequal IDLE cycles already seen; the
  // fourth such cycle sets the sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mm_cnt   <= 2'd0;
      r_mismatch <= 1'b0;
    end else if ((r_state == S_IDLE) && (result_pop != status_pop)) begin
      if (r_mm_cnt == 2'd3) begin
        r_mismatch <= 1'b1;
      end else begin
        r_mm_cnt <= r_mm_cnt + 2'd1;
      end
    end else begin
      r_mm_cnt <= 2'd0;
    end
  end

  assign mismatch = r_mismatch;
`endif

endmodule
